// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with per-entry saturating direction counters.
// Lookup is combinational on pre-edge state; training, allocation, flush and reset act on the rising edge.
module btb_set_assoc #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned SETS  = 8,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned CTR_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            btb_hit,
    output logic            btb_taken,
    output logic [PC_W-1:0] btb_target,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            flush
);

    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned TAG_W = PC_W - SET_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);

    logic             valid_q  [SETS][WAYS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [PC_W-1:0]  target_q [SETS][WAYS];
    logic [CTR_W-1:0] ctr_q    [SETS][WAYS];
    logic [WAY_W-1:0] ptr_q    [SETS];

    logic [SET_W-1:0] fetch_set;
    logic [TAG_W-1:0] fetch_tag;
    logic [SET_W-1:0] upd_set;
    logic [TAG_W-1:0] upd_tag;

    assign fetch_set = fetch_pc[SET_W-1:0];
    assign fetch_tag = fetch_pc[PC_W-1:SET_W];
    assign upd_set   = update_pc[SET_W-1:0];
    assign upd_tag   = update_pc[PC_W-1:SET_W];

    // Ways are scanned high to low so the lowest matching way is the one that sticks.
    always_comb begin
        btb_hit    = 1'b0;
        btb_taken  = 1'b0;
        btb_target = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[fetch_set][w] && (tag_q[fetch_set][w] == fetch_tag)) begin
                btb_hit    = 1'b1;
                btb_taken  = ctr_q[fetch_set][w][CTR_W-1];
                btb_target = target_q[fetch_set][w];
            end
        end
    end

    logic             upd_hit;
    logic [WAY_W-1:0] upd_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] ptr_cur;
    logic [WAY_W-1:0] ptr_next;

    always_comb begin
        upd_hit   = 1'b0;
        upd_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[upd_set][w] && (tag_q[upd_set][w] == upd_tag)) begin
                upd_hit = 1'b1;
                upd_way = WAY_W'(w);
            end
            if (!valid_q[upd_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign ptr_cur    = ptr_q[upd_set];
    assign ptr_next   = (ptr_cur == WAY_LAST) ? '0 : ptr_cur + WAY_W'(1);
    assign victim_way = inv_found ? inv_way : ptr_cur;

    logic [CTR_W-1:0] ctr_sel;
    logic [CTR_W-1:0] ctr_inc;
    logic [CTR_W-1:0] ctr_dec;

    assign ctr_sel = ctr_q[upd_set][upd_way];
    assign ctr_inc = (ctr_sel == CTR_MAX) ? ctr_sel : ctr_sel + CTR_W'(1);
    assign ctr_dec = (ctr_sel == '0) ? ctr_sel : ctr_sel - CTR_W'(1);

    logic do_train;
    logic do_alloc;

    assign do_train = update_valid && upd_hit;
    assign do_alloc = update_valid && !upd_hit && update_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= '0;
                end
            end
        end else if (flush) begin
            // A same-cycle update is intentionally dropped here.
            for (int s = 0; s < int'(SETS); s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            if (do_train) begin
                ctr_q[upd_set][upd_way] <= update_taken ? ctr_inc : ctr_dec;
                if (update_taken) begin
                    target_q[upd_set][upd_way] <= update_target;
                end
            end
            if (do_alloc) begin
                valid_q[upd_set][victim_way]  <= 1'b1;
                tag_q[upd_set][victim_way]    <= upd_tag;
                target_q[upd_set][victim_way] <= update_target;
                ctr_q[upd_set][victim_way]    <= CTR_WEAK;
                // The pointer only moves when it names the entry being evicted.
                if (!inv_found) begin
                    ptr_q[upd_set] <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Self-checking bench for btb_set_assoc: directed scenarios plus randomized traffic
// compared against an array-based behavioural model of the table.
module tb_btb_set_assoc;

    localparam int PC_W  = 8;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int CTR_W = 2;
    localparam int CTR_MAX = (1 << CTR_W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] fetch_pc;
    logic            btb_hit;
    logic            btb_taken;
    logic [PC_W-1:0] btb_target;
    logic            update_valid;
    logic [PC_W-1:0] update_pc;
    logic            update_taken;
    logic [PC_W-1:0] update_target;
    logic            flush;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    btb_set_assoc #(
        .PC_W (PC_W),
        .SETS (SETS),
        .WAYS (WAYS),
        .CTR_W(CTR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc     (fetch_pc),
        .btb_hit      (btb_hit),
        .btb_taken    (btb_taken),
        .btb_target   (btb_target),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .update_target(update_target),
        .flush        (flush)
    );

    // Behavioural model: plain integer arrays, one row per set.
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_tgt   [SETS][WAYS];
    int m_ctr   [SETS][WAYS];
    int m_ptr   [SETS];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = 0;
                m_tgt[s][w]   = 0;
                m_ctr[s][w]   = 0;
            end
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
        end
    endfunction

    function automatic void model_update(int pc, bit tk, int tgt);
        int s;
        int t;
        int victim;
        s = pc % SETS;
        t = pc / SETS;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                if (tk) begin
                    m_ctr[s][w] = (m_ctr[s][w] < CTR_MAX) ? m_ctr[s][w] + 1 : CTR_MAX;
                    m_tgt[s][w] = tgt;
                end else begin
                    m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
                end
                return;
            end
        end
        if (!tk) return;
        victim = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (victim < 0 && !m_valid[s][w]) victim = w;
        end
        if (victim < 0) begin
            victim   = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][victim] = 1;
        m_tag[s][victim]   = t;
        m_tgt[s][victim]   = tgt;
        m_ctr[s][victim]   = 1 << (CTR_W - 1);
    endfunction

    function automatic void model_lookup(input int pc, output bit h, output bit tk, output int tgt);
        int s;
        int t;
        s   = pc % SETS;
        t   = pc / SETS;
        h   = 0;
        tk  = 0;
        tgt = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!h && m_valid[s][w] && m_tag[s][w] == t) begin
                h   = 1;
                tk  = (m_ctr[s][w] >= (1 << (CTR_W - 1)));
                tgt = m_tgt[s][w];
            end
        end
    endfunction

    // One rising edge; the model consumes the inputs the bench drove for that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else if (flush) model_flush();
        else if (update_valid) model_update(int'(update_pc), update_taken, int'(update_target));
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_update(input logic [7:0] pc, input logic tk, input logic [7:0] tgt);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        tick();
        update_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] pc;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pc = 8'($urandom_range(0, 255));
            fetch_pc = pc;
            #1;
            n_total++;
            if (btb_hit !== 1'b0 || btb_taken !== 1'b0 || btb_target !== 8'h00)
                $display("FAIL reset_miss pc=%h: got hit=%b taken=%b tgt=%h, want 0/0/00",
                         pc, btb_hit, btb_taken, btb_target);
            else n_pass++;
        end
    endtask

    task automatic test_cold_alloc();
        do_reset();
        drive_update(8'h13, 1'b1, 8'h40);
        fetch_pc = 8'h13;
        #1;
        n_total++;
        if (btb_hit !== 1'b1 || btb_taken !== 1'b1 || btb_target !== 8'h40)
            $display("FAIL cold_alloc_hit: got hit=%b taken=%b tgt=%h, want 1/1/40",
                     btb_hit, btb_taken, btb_target);
        else n_pass++;
        fetch_pc = 8'h23;
        #1;
        n_total++;
        if (btb_hit !== 1'b0 || btb_target !== 8'h00)
            $display("FAIL cold_alloc_other_tag: got hit=%b tgt=%h, want 0/00", btb_hit, btb_target);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [7:0] exp_tgt;
        do_reset();
        drive_update(8'h13, 1'b1, 8'h40);
        fetch_pc = 8'h13;
        for (int i = 0; i < 3; i++) begin
            drive_update(8'h13, 1'b0, 8'hEE);
            #1;
            n_total++;
            if (btb_hit !== 1'b1 || btb_taken !== 1'b0 || btb_target !== 8'h40)
                $display("FAIL sat_down_%0d: got hit=%b taken=%b tgt=%h, want 1/0/40",
                         i, btb_hit, btb_taken, btb_target);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            exp_tgt = 8'h41 + 8'(i);
            drive_update(8'h13, 1'b1, exp_tgt);
            #1;
            n_total++;
            if (btb_hit !== 1'b1 || btb_taken !== (i == 1) || btb_target !== exp_tgt)
                $display("FAIL sat_up_%0d: got hit=%b taken=%b tgt=%h, want 1/%0d/%h",
                         i, btb_hit, btb_taken, btb_target, (i == 1), exp_tgt);
            else n_pass++;
        end
    endtask

    task automatic test_replacement();
        logic [7:0] pcs  [6];
        logic       want [6];
        do_reset();
        drive_update(8'h03, 1'b1, 8'hA0);
        drive_update(8'h13, 1'b1, 8'hA1);
        drive_update(8'h23, 1'b1, 8'hA2);
        drive_update(8'h33, 1'b1, 8'hA3);
        drive_update(8'h43, 1'b1, 8'hA4);
        // Expected after 0x23 evicts 0x03, 0x33 evicts 0x13, 0x43 evicts 0x23.
        pcs  = '{8'h03, 8'h13, 8'h23, 8'h33, 8'h43, 8'h53};
        want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            fetch_pc = pcs[i];
            #1;
            n_total++;
            if (btb_hit !== want[i])
                $display("FAIL replace pc=%h: got hit=%b, want %b", pcs[i], btb_hit, want[i]);
            else n_pass++;
        end
        fetch_pc = 8'h33;
        #1;
        n_total++;
        if (btb_target !== 8'hA3)
            $display("FAIL replace_target: got %h, want a3", btb_target);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        fetch_pc      = 8'h05;
        update_valid  = 1'b1;
        update_pc     = 8'h05;
        update_taken  = 1'b1;
        update_target = 8'h55;
        #1;
        n_total++;
        if (btb_hit !== 1'b0)
            $display("FAIL same_cycle_pre: got hit=%b, want 0", btb_hit);
        else n_pass++;
        tick();
        update_valid = 1'b0;
        #1;
        n_total++;
        if (btb_hit !== 1'b1 || btb_target !== 8'h55)
            $display("FAIL same_cycle_post: got hit=%b tgt=%h, want 1/55", btb_hit, btb_target);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [7:0] pcs [3];
        do_reset();
        drive_update(8'h17, 1'b1, 8'h70);
        drive_update(8'h27, 1'b1, 8'h71);
        flush = 1'b1;
        drive_update(8'h07, 1'b1, 8'h72);
        flush = 1'b0;
        pcs = '{8'h07, 8'h17, 8'h27};
        for (int i = 0; i < 3; i++) begin
            fetch_pc = pcs[i];
            #1;
            n_total++;
            if (btb_hit !== 1'b0)
                $display("FAIL flush_miss pc=%h: got hit=%b, want 0", pcs[i], btb_hit);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_update(8'h11, 1'b1, 8'h10);
        drive_update(8'h21, 1'b1, 8'h20);
        drive_update(8'h31, 1'b1, 8'h30);
        do_reset();
        fetch_pc = 8'h21;
        #1;
        n_total++;
        if (btb_hit !== 1'b0)
            $display("FAIL reset_mid_miss: got hit=%b, want 0", btb_hit);
        else n_pass++;
        // Fresh pointer means the third allocation evicts the first one, which sat in way 0.
        drive_update(8'h41, 1'b1, 8'h40);
        drive_update(8'h51, 1'b1, 8'h50);
        drive_update(8'h61, 1'b1, 8'h60);
        fetch_pc = 8'h41;
        #1;
        n_total++;
        if (btb_hit !== 1'b0)
            $display("FAIL reset_mid_way0: got hit=%b, want 0", btb_hit);
        else n_pass++;
        fetch_pc = 8'h51;
        #1;
        n_total++;
        if (btb_hit !== 1'b1 || btb_target !== 8'h50)
            $display("FAIL reset_mid_way1: got hit=%b tgt=%h, want 1/50", btb_hit, btb_target);
        else n_pass++;
    endtask

    task automatic test_random();
        bit exp_hit;
        bit exp_tk;
        int exp_tgt;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            update_valid  = ($urandom_range(0, 99) < 60);
            update_pc     = 8'($urandom_range(0, 47));
            update_taken  = ($urandom_range(0, 99) < 65);
            update_target = 8'($urandom_range(0, 255));
            flush         = ($urandom_range(0, 99) < 3);
            fetch_pc      = (i % 3 == 0) ? update_pc : 8'($urandom_range(0, 47));
            #1;
            model_lookup(int'(fetch_pc), exp_hit, exp_tk, exp_tgt);
            n_total++;
            if (btb_hit !== exp_hit || btb_taken !== exp_tk || btb_target !== 8'(exp_tgt))
                $display("FAIL random_%0d pc=%h: got hit=%b taken=%b tgt=%h, want %b/%b/%h",
                         i, fetch_pc, btb_hit, btb_taken, btb_target, exp_hit, exp_tk,
                         8'(exp_tgt));
            else n_pass++;
            tick();
        end
        update_valid = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        fetch_pc      = '0;
        update_valid  = 1'b0;
        update_pc     = '0;
        update_taken  = 1'b0;
        update_target = '0;
        flush         = 1'b0;
        model_reset();
        test_reset();
        test_cold_alloc();
        test_saturation();
        test_replacement();
        test_same_cycle();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
